// File: rtl/id_ex_stage.sv
// id_ex_stage: ID/EX pipeline register feeding the ALU.
//   Latches decoded operands and control at the end of ID, resolves the EX
//   source operands through EX/MEM and MEM/WB forwarding, drives ALU operands
//   and control in EX, and flags load-use hazards against the instruction in ID.
//
// Optional feature macro: ID_EX_FORWARD_EN
//   defined   : forwarding muxes on both EX sources; hazard_o is load-use only.
//   undefined : no forwarding; hazard_o also covers any pending register write
//               in EX, EX/MEM or MEM/WB that matches a valid ID source.
//
// Ports:
//   clk_i, rst_n_i           clock, asynchronous active-low reset
//   stall_i, flush_i         hold stage / load bubble (flush wins)
//   id_*                     decoded instruction from ID
//   exm_*, mwb_*             EX/MEM and MEM/WB write ports used for forwarding
//   data1_o, data2_o         ALU operands (combinational from stage registers)
//   alu_ctrl_o               ALU operation
//   store_data_o             forwarded rs2 value for stores
//   ex_*_o                   registered destination and control
//   hazard_o                 combinational load-use hazard
module id_ex_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned REG_AW = 5,
  parameter int unsigned CTRL_W = 3
) (
  input  logic              clk_i,
  input  logic              rst_n_i,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              id_valid_i,
  input  logic [DATA_W-1:0] id_rs1_data_i,
  input  logic [DATA_W-1:0] id_rs2_data_i,
  input  logic [DATA_W-1:0] id_imm_i,
  input  logic [REG_AW-1:0] id_rs1_addr_i,
  input  logic [REG_AW-1:0] id_rs2_addr_i,
  input  logic [REG_AW-1:0] id_rd_addr_i,
  input  logic [CTRL_W-1:0] id_alu_ctrl_i,
  input  logic              id_alu_src_i,
  input  logic              id_reg_write_i,
  input  logic              id_mem_read_i,
  input  logic              id_mem_write_i,
  input  logic              id_mem_to_reg_i,
  input  logic              exm_reg_write_i,
  input  logic [REG_AW-1:0] exm_rd_addr_i,
  input  logic [DATA_W-1:0] exm_result_i,
  input  logic              mwb_reg_write_i,
  input  logic [REG_AW-1:0] mwb_rd_addr_i,
  input  logic [DATA_W-1:0] mwb_data_i,
  output logic [DATA_W-1:0] data1_o,
  output logic [DATA_W-1:0] data2_o,
  output logic [CTRL_W-1:0] alu_ctrl_o,
  output logic [DATA_W-1:0] store_data_o,
  output logic [REG_AW-1:0] ex_rd_addr_o,
  output logic              ex_valid_o,
  output logic              ex_reg_write_o,
  output logic              ex_mem_read_o,
  output logic              ex_mem_write_o,
  output logic              ex_mem_to_reg_o,
  output logic              hazard_o
);

  // Everything latched from ID; the all-zero value is the bubble.
  typedef struct packed {
    logic              valid;
    logic              reg_write;
    logic              mem_read;
    logic              mem_write;
    logic              mem_to_reg;
    logic              alu_src;
    logic [CTRL_W-1:0] alu_ctrl;
    logic [DATA_W-1:0] rs1_data;
    logic [DATA_W-1:0] rs2_data;
    logic [DATA_W-1:0] imm;
    logic [REG_AW-1:0] rs1_addr;
    logic [REG_AW-1:0] rs2_addr;
    logic [REG_AW-1:0] rd_addr;
  } ex_regs_t;

  ex_regs_t          ex_q;
  ex_regs_t          ex_d;
  logic [DATA_W-1:0] rs1_fwd_c;
  logic [DATA_W-1:0] rs2_fwd_c;
  logic              load_use_c;

  // Next-state: flush > stall > load.
  always_comb begin : stage_next
    ex_d = ex_q;
    if (flush_i) begin
      ex_d = '0;
    end else if (!stall_i) begin
      ex_d.valid      = id_valid_i;
      ex_d.reg_write  = id_reg_write_i;
      ex_d.mem_read   = id_mem_read_i;
      ex_d.mem_write  = id_mem_write_i;
      ex_d.mem_to_reg = id_mem_to_reg_i;
      ex_d.alu_src    = id_alu_src_i;
      ex_d.alu_ctrl   = id_alu_ctrl_i;
      ex_d.rs1_data   = id_rs1_data_i;
      ex_d.rs2_data   = id_rs2_data_i;
      ex_d.imm        = id_imm_i;
      ex_d.rs1_addr   = id_rs1_addr_i;
      ex_d.rs2_addr   = id_rs2_addr_i;
      ex_d.rd_addr    = id_rd_addr_i;
    end
  end

  // Stage register.
  always_ff @(posedge clk_i or negedge rst_n_i) begin : stage_reg
    if (!rst_n_i) begin
      ex_q <= '0;
    end else begin
      ex_q <= ex_d;
    end
  end

`ifdef ID_EX_FORWARD_EN
  // Operand forwarding: EX/MEM is younger so it beats MEM/WB; x0 never forwards.
  always_comb begin : forward_mux
    rs1_fwd_c = ex_q.rs1_data;
    rs2_fwd_c = ex_q.rs2_data;
    if (exm_reg_write_i && (exm_rd_addr_i != '0) && (exm_rd_addr_i == ex_q.rs1_addr)) begin
      rs1_fwd_c = exm_result_i;
    end else if (mwb_reg_write_i && (mwb_rd_addr_i != '0) && (mwb_rd_addr_i == ex_q.rs1_addr)) begin
      rs1_fwd_c = mwb_data_i;
    end
    if (exm_reg_write_i && (exm_rd_addr_i != '0) && (exm_rd_addr_i == ex_q.rs2_addr)) begin
      rs2_fwd_c = exm_result_i;
    end else if (mwb_reg_write_i && (mwb_rd_addr_i != '0) && (mwb_rd_addr_i == ex_q.rs2_addr)) begin
      rs2_fwd_c = mwb_data_i;
    end
  end
`else
  // No forwarding: operands come straight from the latched register-file reads.
  always_comb begin : forward_mux
    rs1_fwd_c = ex_q.rs1_data;
    rs2_fwd_c = ex_q.rs2_data;
  end

  // Forwarding-only inputs and fields are intentionally ignored in this build.
  logic unused_fwd;
  assign unused_fwd = ^{exm_result_i, mwb_data_i, ex_q.rs1_addr, ex_q.rs2_addr};

  // True when a nonzero ID source has a write still pending further down the pipe.
  function automatic logic src_pending(
    input logic [REG_AW-1:0] src,
    input logic              ex_we,
    input logic [REG_AW-1:0] ex_rd,
    input logic              exm_we,
    input logic [REG_AW-1:0] exm_rd,
    input logic              mwb_we,
    input logic [REG_AW-1:0] mwb_rd
  );
    return (src != '0) && ((ex_we && (ex_rd == src)) ||
                           (exm_we && (exm_rd == src)) ||
                           (mwb_we && (mwb_rd == src)));
  endfunction
`endif

  // Hazard detection against the instruction currently in ID.
  always_comb begin : hazard_detect
    load_use_c = id_valid_i && ex_q.valid && ex_q.mem_read && (ex_q.rd_addr != '0) &&
                 ((ex_q.rd_addr == id_rs1_addr_i) || (ex_q.rd_addr == id_rs2_addr_i));
    hazard_o   = load_use_c;
`ifndef ID_EX_FORWARD_EN
    if (id_valid_i &&
        (src_pending(id_rs1_addr_i, ex_q.valid && ex_q.reg_write, ex_q.rd_addr,
                     exm_reg_write_i, exm_rd_addr_i, mwb_reg_write_i, mwb_rd_addr_i) ||
         src_pending(id_rs2_addr_i, ex_q.valid && ex_q.reg_write, ex_q.rd_addr,
                     exm_reg_write_i, exm_rd_addr_i, mwb_reg_write_i, mwb_rd_addr_i))) begin
      hazard_o = 1'b1;
    end
`endif
  end

  assign data1_o         = rs1_fwd_c;
  assign data2_o         = ex_q.alu_src ? ex_q.imm : rs2_fwd_c;
  assign store_data_o    = rs2_fwd_c;
  assign alu_ctrl_o      = ex_q.alu_ctrl;
  assign ex_rd_addr_o    = ex_q.rd_addr;
  assign ex_valid_o      = ex_q.valid;
  assign ex_reg_write_o  = ex_q.reg_write;
  assign ex_mem_read_o   = ex_q.mem_read;
  assign ex_mem_write_o  = ex_q.mem_write;
  assign ex_mem_to_reg_o = ex_q.mem_to_reg;

endmodule
